// File: rtl/sad_datapath_if.sv
// Controller, host-write and result signals of the SAD datapath.
// The best-result outputs exist only when SAD_BEST_TRACK_EN is defined.
interface sad_datapath_if #(
   parameter int DATA_W = 8
);
   logic              AB_rd;
   logic              i_inc;
   logic              i_clr;
   logic              sum_ld;
   logic              sum_clr;
   logic              sad_reg_ld;
   logic              i_lt_256;
   logic              wr_en;
   logic              wr_sel;
   logic [7:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W+7:0] sad;
   logic              sad_valid;
`ifdef SAD_BEST_TRACK_EN
   logic [DATA_W+7:0] best_sad;
   logic              best_valid;
`endif

   // Controller and host side.
   modport master (
      output AB_rd, i_inc, i_clr, sum_ld, sum_clr, sad_reg_ld,
      output wr_en, wr_sel, wr_addr, wr_data,
      input  i_lt_256, sad, sad_valid
`ifdef SAD_BEST_TRACK_EN
      , input best_sad, best_valid
`endif
   );

   // Datapath side.
   modport slave (
      input  AB_rd, i_inc, i_clr, sum_ld, sum_clr, sad_reg_ld,
      input  wr_en, wr_sel, wr_addr, wr_data,
      output i_lt_256, sad, sad_valid
`ifdef SAD_BEST_TRACK_EN
      , output best_sad, best_valid
`endif
   );
endinterface

// File: rtl/sad_datapath.sv
// Sum-of-absolute-differences datapath over two 256-entry pixel memories.
// Optional minimum-result tracking is enabled by defining SAD_BEST_TRACK_EN.
module sad_datapath #(
   parameter int DATA_W = 8
) (
   input logic            clk,
   input logic            rst,
   sad_datapath_if.slave  bus
);
   localparam int SUM_W = DATA_W + 8;

   logic [8:0]        i_reg;
   logic [SUM_W-1:0]  sum_reg;
   logic [SUM_W-1:0]  sad_reg;
   logic              sad_valid_reg;
   logic [DATA_W-1:0] rd_data [2];
   logic [DATA_W-1:0] absdiff;
   logic              accum;

   // Bank 0 is memory A, bank 1 is memory B. The read is combinational from
   // the array, so a same-cycle write at the read address returns old data.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_mem
         logic [DATA_W-1:0] mem [256];

         always_ff @(posedge clk) begin
            if (bus.wr_en && (bus.wr_sel == 1'(gi))) begin
               mem[bus.wr_addr] <= bus.wr_data;
            end
         end

         assign rd_data[gi] = mem[i_reg[7:0]];
      end
   endgenerate

   assign absdiff = (rd_data[0] >= rd_data[1]) ? (rd_data[0] - rd_data[1])
                                               : (rd_data[1] - rd_data[0]);
   assign bus.i_lt_256 = (i_reg < 9'd256);
   assign accum = bus.sum_ld && bus.AB_rd && bus.i_lt_256;

   // Index saturates at 256 so the controller sees a stable "done" status.
   always_ff @(posedge clk) begin
      if (rst) begin
         i_reg <= '0;
      end else if (bus.i_clr) begin
         i_reg <= '0;
      end else if (bus.i_inc && (i_reg != 9'd256)) begin
         i_reg <= i_reg + 9'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_reg <= '0;
      end else if (bus.sum_clr) begin
         sum_reg <= '0;
      end else if (accum) begin
         sum_reg <= sum_reg + SUM_W'(absdiff);
      end
   end

   // A simultaneous sum_clr still lets sad capture the pre-clear sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         sad_reg       <= '0;
         sad_valid_reg <= 1'b0;
      end else begin
         if (bus.sad_reg_ld) begin
            sad_reg <= sum_reg;
         end
         if (bus.sum_clr) begin
            sad_valid_reg <= 1'b0;
         end else if (bus.sad_reg_ld) begin
            sad_valid_reg <= 1'b1;
         end
      end
   end

   assign bus.sad       = sad_reg;
   assign bus.sad_valid = sad_valid_reg;

`ifdef SAD_BEST_TRACK_EN
   logic [SUM_W-1:0] best_sad_reg;
   logic             best_valid_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         best_sad_reg   <= '0;
         best_valid_reg <= 1'b0;
      end else if (bus.sad_reg_ld && (!best_valid_reg || (sum_reg < best_sad_reg))) begin
         best_sad_reg   <= sum_reg;
         best_valid_reg <= 1'b1;
      end
   end

   assign bus.best_sad   = best_sad_reg;
   assign bus.best_valid = best_valid_reg;
`endif
endmodule

// File: tb/tb_sad_datapath.sv
// Directed and randomized checks of sad_datapath against array-based sums.
// Best-result checks are compiled in when SAD_BEST_TRACK_EN is defined.
module tb_sad_datapath;
   localparam int DATA_W = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   a_m [256];
   int   b_m [256];
   int   exp_sad;

   sad_datapath_if #(.DATA_W(DATA_W)) bus ();

   sad_datapath #(.DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      $display("check %s: observed %0d expected %0d", tag, obs, exp);
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic ctl_idle();
      bus.AB_rd      = 1'b0;
      bus.i_inc      = 1'b0;
      bus.i_clr      = 1'b0;
      bus.sum_ld     = 1'b0;
      bus.sum_clr    = 1'b0;
      bus.sad_reg_ld = 1'b0;
      bus.wr_en      = 1'b0;
      bus.wr_sel     = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
   endtask

   function automatic int ref_sad();
      int s = 0;
      for (int k = 0; k < 256; k++) begin
         s += (a_m[k] > b_m[k]) ? (a_m[k] - b_m[k]) : (b_m[k] - a_m[k]);
      end
      return s;
   endfunction

   // Copies the model arrays into the DUT memories.
   task automatic load_mem();
      for (int k = 0; k < 256; k++) begin
         for (int s = 0; s < 2; s++) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = s[0];
            bus.wr_addr = 8'(k);
            bus.wr_data = (s == 0) ? DATA_W'(a_m[k]) : DATA_W'(b_m[k]);
            tick();
         end
      end
      ctl_idle();
   endtask

   // Controller sequence: S1, 256 x (S2,S3), S2, S4. Optionally resets at
   // index abort_at, or writes inj_val into A[inj_k] during the S2 read of inj_k.
   task automatic run_full(input int abort_at, input int inj_k, input int inj_val);
      ctl_idle();
      bus.i_clr = 1'b1; bus.sum_clr = 1'b1;
      tick(); ctl_idle();
      for (int k = 0; k < 256; k++) begin
         if (k == abort_at) begin
            rst = 1'b1; bus.sum_ld = 1'b1; bus.AB_rd = 1'b1; bus.sad_reg_ld = 1'b1;
            tick(); rst = 1'b0; ctl_idle();
            return;
         end
         bus.AB_rd = 1'b1; bus.sum_ld = 1'b1;
         if (k == inj_k) begin
            bus.wr_en = 1'b1; bus.wr_sel = 1'b0;
            bus.wr_addr = 8'(k); bus.wr_data = DATA_W'(inj_val);
         end
         tick(); ctl_idle();
         if (k == inj_k) a_m[k] = inj_val;
         bus.i_inc = 1'b1;
         tick(); ctl_idle();
      end
      check("i_lt_256_end_of_run", 32'(bus.i_lt_256), 32'd0);
      bus.AB_rd = 1'b1; bus.sum_ld = 1'b1;
      tick(); ctl_idle();
      check("sad_valid_before_load", 32'(bus.sad_valid), 32'd0);
      bus.sad_reg_ld = 1'b1;
      tick(); ctl_idle();
      check("sad_valid_after_load", 32'(bus.sad_valid), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      ctl_idle();
      tick(); tick();
      rst = 1'b0;
      check("reset_sad", 32'(bus.sad), 32'd0);
      check("reset_sad_valid", 32'(bus.sad_valid), 32'd0);
      check("reset_i_lt_256", 32'(bus.i_lt_256), 32'd1);

      // Ramp against zero.
      for (int k = 0; k < 256; k++) begin a_m[k] = k; b_m[k] = 0; end
      load_mem();
      run_full(-1, -1, 0);
      check("ramp_sad", 32'(bus.sad), 32'(ref_sad()));
      check("ramp_sad_const", 32'(bus.sad), 32'd32640);

      // sum_clr alone drops valid but keeps the result.
      bus.sum_clr = 1'b1; tick(); ctl_idle();
      check("sum_clr_valid", 32'(bus.sad_valid), 32'd0);
      check("sum_clr_keeps_sad", 32'(bus.sad), 32'd32640);

      // Accumulate only A[3]-B[3]=3, then load and clear together.
      bus.i_clr = 1'b1; tick(); ctl_idle();
      for (int n = 0; n < 3; n++) begin bus.i_inc = 1'b1; tick(); ctl_idle(); end
      bus.AB_rd = 1'b1; bus.sum_ld = 1'b1; tick(); ctl_idle();
      bus.sum_ld = 1'b1; tick(); ctl_idle();
      bus.sad_reg_ld = 1'b1; bus.sum_clr = 1'b1; tick(); ctl_idle();
      check("ld_clr_sad", 32'(bus.sad), 32'd3);
      check("ld_clr_valid", 32'(bus.sad_valid), 32'd0);
      bus.sad_reg_ld = 1'b1; tick(); ctl_idle();
      check("ld_after_clr_sad", 32'(bus.sad), 32'd0);
      check("ld_after_clr_valid", 32'(bus.sad_valid), 32'd1);

      // Saturation: accumulate at i=7, then keep incrementing to 300 steps.
      bus.i_clr = 1'b1; bus.sum_clr = 1'b1; tick(); ctl_idle();
      for (int n = 1; n <= 300; n++) begin
         if (n == 8) begin
            bus.AB_rd = 1'b1; bus.sum_ld = 1'b1; tick(); ctl_idle();
         end
         bus.i_inc = 1'b1; tick(); ctl_idle();
         if (n == 255 || n == 256 || n == 300)
            check($sformatf("i_lt_256_after_%0d_inc", n), 32'(bus.i_lt_256), 32'(n < 256));
      end
      for (int n = 0; n < 3; n++) begin
         bus.AB_rd = 1'b1; bus.sum_ld = 1'b1; tick(); ctl_idle();
      end
      bus.sum_ld = 1'b1; bus.i_inc = 1'b1; tick(); ctl_idle();
      bus.sad_reg_ld = 1'b1; tick(); ctl_idle();
      check("saturated_sum_unchanged", 32'(bus.sad), 32'd7);

      // Largest possible result.
      for (int k = 0; k < 256; k++) begin a_m[k] = 0; b_m[k] = 255; end
      load_mem();
      run_full(-1, -1, 0);
      check("max_sad", 32'(bus.sad), 32'(ref_sad()));
      check("max_sad_const", 32'(bus.sad), 32'd65280);

      // Identical memories.
      for (int k = 0; k < 256; k++) begin a_m[k] = $urandom_range(0, 255); b_m[k] = a_m[k]; end
      load_mem();
      run_full(-1, -1, 0);
      check("equal_sad", 32'(bus.sad), 32'd0);

      // Random data, then an aborted run at i=100, then a clean rerun.
      for (int k = 0; k < 256; k++) begin a_m[k] = $urandom_range(0, 255); b_m[k] = $urandom_range(0, 255); end
      load_mem();
      run_full(-1, -1, 0);
      check("random_sad", 32'(bus.sad), 32'(ref_sad()));
      run_full(100, -1, 0);
      check("abort_i_lt_256", 32'(bus.i_lt_256), 32'd1);
      check("abort_sad", 32'(bus.sad), 32'd0);
      check("abort_sad_valid", 32'(bus.sad_valid), 32'd0);
      run_full(-1, -1, 0);
      check("rerun_sad", 32'(bus.sad), 32'(ref_sad()));

      // Write-during-read at address 5: old value 10 counts this run.
      for (int k = 0; k < 256; k++) begin a_m[k] = $urandom_range(0, 255); b_m[k] = $urandom_range(0, 255); end
      a_m[5] = 10; b_m[5] = 0;
      load_mem();
      exp_sad = ref_sad();
      run_full(-1, 5, 200);
      check("wr_during_rd_sad", 32'(bus.sad), 32'(exp_sad));
      run_full(-1, -1, 0);
      check("wr_visible_next_run", 32'(bus.sad), 32'(ref_sad()));

`ifdef SAD_BEST_TRACK_EN
      begin
         int results [3] = '{500, 300, 400};
         int best_m = -1;
         rst = 1'b1; tick(); rst = 1'b0;
         check("best_reset_valid", 32'(bus.best_valid), 32'd0);
         for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 256; k++) begin a_m[k] = 0; b_m[k] = 0; end
            b_m[0] = results[r] / 2; b_m[1] = results[r] - b_m[0];
            load_mem();
            run_full(-1, -1, 0);
            if (best_m < 0 || results[r] < best_m) best_m = results[r];
            check($sformatf("best_run%0d_sad", r), 32'(bus.sad), 32'(results[r]));
            check($sformatf("best_run%0d_best", r), 32'(bus.best_sad), 32'(best_m));
            check($sformatf("best_run%0d_valid", r), 32'(bus.best_valid), 32'd1);
         end
         bus.sum_clr = 1'b1; tick(); ctl_idle();
         check("best_kept_on_sum_clr", 32'(bus.best_sad), 32'd300);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
